mem_bus_access_unit: RTL and testbench

- M-stage memory access controller for the P6/P7 pipeline.
- Accepts one load or store per instruction from the M stage, already carrying byte enables and lane-aligned write data.
- Runs the access on a variable-latency req/gnt/rvalid data bus, stalling the pipeline until it completes.
- Delivers sign/zero-extended load data to the W stage.

---
 rtl/mem_bus_access_unit_if.sv | 23 ++
 rtl/mem_bus_access_unit.sv | 153 +++++++++++++++
 tb/tb_mem_bus_access_unit.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_access_unit_if.sv
// Data-bus handshake between the M-stage access unit and memory.
interface mem_bus_access_unit_if;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic        bus_we;
  logic [3:0]  bus_byteen;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  // Access unit side: issues requests, receives grant and read data.
  modport master (
    output bus_req, bus_addr, bus_we, bus_byteen, bus_wdata,
    input  bus_gnt, bus_rvalid, bus_rdata
  );

  // Memory side.
  modport slave (
    input  bus_req, bus_addr, bus_we, bus_byteen, bus_wdata,
    output bus_gnt, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/mem_bus_access_unit.sv
// M-stage memory access controller: runs one load/store per instruction on a
// req/gnt/rvalid bus, stalls the pipeline meanwhile, and returns extended
// load data to W. A watchdog aborts accesses that make no progress.
module mem_bus_access_unit #(
  parameter int unsigned TIMEOUT_CYC = 1023,
  parameter int unsigned CNT_W       = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m_valid,
  input  logic                  m_we,
  input  logic [3:0]            m_byteen,
  input  logic [31:0]           m_addr,
  input  logic [31:0]           m_wdata,
  input  logic [2:0]            m_ldop,
  output logic                  m_stall,
  output logic                  m_exc,
  mem_bus_access_unit_if.master bus,
  output logic                  w_valid,
  output logic [31:0]           w_rdata,
  output logic                  bus_err
);

  localparam logic [2:0] LD_LB  = 3'd1;
  localparam logic [2:0] LD_LBU = 3'd2;
  localparam logic [2:0] LD_LH  = 3'd3;
  localparam logic [2:0] LD_LHU = 3'd4;

  // Timeout fires on the cycle whose increment would reach TIMEOUT_CYC.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, wdata_q, w_rdata_q;
  logic             we_q, bus_req_q, w_valid_q, bus_err_q;
  logic [3:0]       byteen_q;
  logic [2:0]       ldop_q;
  logic             is_half, is_word, accept, timeout;

  // Select and extend the addressed byte/half of the returned word.
  function automatic logic [31:0] extend_load(input logic [2:0]  op,
                                              input logic [1:0]  off,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (op)
      LD_LB:   extend_load = {{24{b[7]}}, b};
      LD_LBU:  extend_load = {24'd0, b};
      LD_LH:   extend_load = {{16{h[15]}}, h};
      LD_LHU:  extend_load = {16'd0, h};
      default: extend_load = word;
    endcase
  endfunction

  // Decode, misalignment check, accept and stall from the live M-stage inputs.
  always_comb begin
    is_half = (m_ldop == LD_LH) | (m_ldop == LD_LHU);
    is_word = ~(is_half | (m_ldop == LD_LB) | (m_ldop == LD_LBU));
    m_exc   = m_valid & ~m_we &
              ((is_word & (m_addr[1:0] != 2'b00)) | (is_half & m_addr[0]));
    accept  = m_valid & ~m_exc & ~(m_we & (m_byteen == 4'b0000));
    m_stall = ((state_q == S_IDLE) & accept) | (state_q == S_REQ) |
              (state_q == S_WAIT);
    cnt_d   = cnt_q + CNT_W'(1);
    timeout = (cnt_q >= CNT_LAST);
  end

  // Access FSM with registered bus and writeback outputs; grant/rvalid beat timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      byteen_q  <= '0;
      ldop_q    <= '0;
      bus_req_q <= 1'b0;
      w_valid_q <= 1'b0;
      w_rdata_q <= '0;
      bus_err_q <= 1'b0;
    end else begin
      w_valid_q <= 1'b0;
      bus_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            addr_q    <= m_addr;
            wdata_q   <= m_wdata;
            we_q      <= m_we;
            byteen_q  <= m_byteen;
            ldop_q    <= m_ldop;
            cnt_q     <= '0;
            bus_req_q <= 1'b1;
            state_q   <= S_REQ;
          end
        end
        S_REQ: begin
          cnt_q <= cnt_d;
          if (bus.bus_gnt) begin
            bus_req_q <= 1'b0;
            if (we_q) begin
              w_valid_q <= 1'b1;
              state_q   <= S_DONE;
            end else begin
              state_q <= S_WAIT;
            end
          end else if (timeout) begin
            bus_req_q <= 1'b0;
            w_valid_q <= 1'b1;
            bus_err_q <= 1'b1;
            if (!we_q) w_rdata_q <= '0;
            state_q   <= S_DONE;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_d;
          if (bus.bus_rvalid) begin
            w_rdata_q <= extend_load(ldop_q, addr_q[1:0], bus.bus_rdata);
            w_valid_q <= 1'b1;
            state_q   <= S_DONE;
          end else if (timeout) begin
            w_rdata_q <= '0;
            w_valid_q <= 1'b1;
            bus_err_q <= 1'b1;
            state_q   <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.bus_req    = bus_req_q;
  assign bus.bus_addr   = {addr_q[31:2], 2'b00};
  assign bus.bus_we     = we_q;
  assign bus.bus_byteen = byteen_q;
  assign bus.bus_wdata  = wdata_q;
  assign w_valid        = w_valid_q;
  assign w_rdata        = w_rdata_q;
  assign bus_err        = bus_err_q;

endmodule

// File: tb/tb_mem_bus_access_unit.sv
// Scoreboarded bench for mem_bus_access_unit with a short timeout.
module tb_mem_bus_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        m_valid, m_we;
  logic [3:0]  m_byteen;
  logic [31:0] m_addr, m_wdata;
  logic [2:0]  m_ldop;
  logic        m_stall, m_exc, w_valid, bus_err;
  logic [31:0] w_rdata;
  logic [31:0] last_rd;

  int n_cmp = 0;
  int n_err = 0;

  // Expected completions: {bus_err, w_rdata}
  logic [32:0] sb_q[$];

  mem_bus_access_unit_if bus_if();

  mem_bus_access_unit #(.TIMEOUT_CYC(8), .CNT_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .m_valid  (m_valid),
    .m_we     (m_we),
    .m_byteen (m_byteen),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_ldop   (m_ldop),
    .m_stall  (m_stall),
    .m_exc    (m_exc),
    .bus      (bus_if),
    .w_valid  (w_valid),
    .w_rdata  (w_rdata),
    .bus_err  (bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Completion monitor: every w_valid pulse consumes one expected entry.
  always @(negedge clk) begin
    if (!reset) begin
      if (w_valid) begin
        if (sb_q.size() == 0) begin
          check("unexpected_w_valid", 32'(w_valid), 32'd0);
        end else begin
          logic [32:0] e;
          e = sb_q.pop_front();
          check("w_rdata", w_rdata, e[31:0]);
          check("bus_err", 32'(bus_err), 32'(e[32]));
        end
      end else if (bus_err) begin
        check("stray_bus_err", 32'(bus_err), 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got hang expected finish");
    $fatal(1, "watchdog");
  end

  // One accepted access; gnt_dly<0 means never grant, rv_dly counts WAIT cycles.
  task automatic run_access(input logic we, input logic [3:0] be, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [2:0] ldop,
                            input int gnt_dly, input int rv_dly, input logic [31:0] rdata,
                            input logic [31:0] exp_rd, input logic exp_err, input int exp_stall);
    int stall_n, req_n, wait_n;
    bit granted, done;
    logic [31:0] tmp;
    @(posedge clk); #1;
    m_valid = 1'b1; m_we = we; m_byteen = be; m_addr = addr; m_wdata = wdata; m_ldop = ldop;
    sb_q.push_back({exp_err, exp_rd});
    if (!we) last_rd = exp_rd;
    stall_n = 0; req_n = 0; wait_n = 0; granted = 1'b0; done = 1'b0;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk); #1;
        bus_if.bus_gnt = 1'b0; bus_if.bus_rvalid = 1'b0; bus_if.bus_rdata = '0;
        if (cyc > 1) begin
          tmp = $urandom;
          m_addr  = {tmp[31:2], addr[1:0]};
          m_wdata = $urandom;
        end
      end
      @(negedge clk);
      if (m_stall) stall_n++;
      if (bus_if.bus_req) begin
        req_n++;
        check("bus_addr", bus_if.bus_addr, {addr[31:2], 2'b00});
        check("bus_we", 32'(bus_if.bus_we), 32'(we));
        check("bus_byteen", 32'(bus_if.bus_byteen), 32'(be));
        check("bus_wdata", bus_if.bus_wdata, wdata);
        if (gnt_dly >= 0 && req_n - 1 == gnt_dly) begin
          bus_if.bus_gnt = 1'b1;
          granted = 1'b1;
        end
        if (!we) begin
          bus_if.bus_rvalid = 1'b1;
          bus_if.bus_rdata  = 32'hBAD0_BAD0;
        end
      end else if (granted && m_stall) begin
        wait_n++;
        if (wait_n == rv_dly) begin
          bus_if.bus_rvalid = 1'b1;
          bus_if.bus_rdata  = rdata;
        end
      end
      if (!m_stall && cyc > 0) begin
        done = 1'b1;
        bus_if.bus_rvalid = 1'b1;
        bus_if.bus_rdata  = 32'h5A5A_5A5A;
      end
    end
    check("access_done", 32'(done), 32'd1);
    check("stall_cycles", 32'(stall_n), 32'(exp_stall));
    @(posedge clk); #1;
    m_valid = 1'b0; bus_if.bus_gnt = 1'b0; bus_if.bus_rvalid = 1'b0; bus_if.bus_rdata = '0;
    @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    check("idle_bus_req", 32'(bus_if.bus_req), 32'd0);
  endtask

  // Instruction that must not reach the bus (misaligned load or empty store).
  task automatic no_access(input logic we, input logic [3:0] be, input logic [31:0] addr,
                           input logic [2:0] ldop, input logic exp_exc);
    @(posedge clk); #1;
    m_valid = 1'b1; m_we = we; m_byteen = be; m_addr = addr; m_wdata = 32'h1111_2222; m_ldop = ldop;
    bus_if.bus_rvalid = 1'b1; bus_if.bus_rdata = 32'h7777_7777;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("m_exc", 32'(m_exc), 32'(exp_exc));
      check("noacc_stall", 32'(m_stall), 32'd0);
      check("noacc_req", 32'(bus_if.bus_req), 32'd0);
      @(posedge clk); #1;
    end
    m_valid = 1'b0; bus_if.bus_rvalid = 1'b0; bus_if.bus_rdata = '0;
    check("noacc_w_rdata", w_rdata, last_rd);
  endtask

  initial begin
    reset = 1'b1;
    m_valid = 1'b0; m_we = 1'b0; m_byteen = '0; m_addr = '0; m_wdata = '0; m_ldop = '0;
    bus_if.bus_gnt = 1'b0; bus_if.bus_rvalid = 1'b0; bus_if.bus_rdata = '0;
    last_rd = '0;
    repeat (2) @(negedge clk);
    check("rst_bus_req", 32'(bus_if.bus_req), 32'd0);
    check("rst_bus_addr", bus_if.bus_addr, 32'd0);
    check("rst_bus_we", 32'(bus_if.bus_we), 32'd0);
    check("rst_bus_byteen", 32'(bus_if.bus_byteen), 32'd0);
    check("rst_bus_wdata", bus_if.bus_wdata, 32'd0);
    check("rst_w_valid", 32'(w_valid), 32'd0);
    check("rst_w_rdata", w_rdata, 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    check("rst_m_stall", 32'(m_stall), 32'd0);
    reset = 1'b0;

    //         we    be       addr          wdata          op    gnt rv rdata          exp_rd         err stall
    run_access(1'b1, 4'hF,    32'h0000_1004, 32'hDEAD_BEEF, 3'd0, 0, 0, 32'h0,         last_rd,       1'b0, 2);
    run_access(1'b0, 4'h0,    32'h0000_2003, 32'h0,         3'd1, 3, 2, 32'h80FF_7F01, 32'hFFFF_FF80, 1'b0, 7);
    run_access(1'b0, 4'h0,    32'h0000_2001, 32'h0,         3'd2, 0, 1, 32'h80FF_7F01, 32'h0000_007F, 1'b0, 3);
    run_access(1'b0, 4'h0,    32'h0000_2002, 32'h0,         3'd3, 1, 3, 32'h80FF_7F01, 32'hFFFF_80FF, 1'b0, 6);
    run_access(1'b0, 4'h0,    32'h0000_2002, 32'h0,         3'd4, 0, 1, 32'h80FF_7F01, 32'h0000_80FF, 1'b0, 3);
    run_access(1'b0, 4'h0,    32'h0000_2000, 32'h0,         3'd0, 0, 1, 32'h80FF_7F01, 32'h80FF_7F01, 1'b0, 3);
    run_access(1'b0, 4'h0,    32'h0000_2000, 32'h0,         3'd7, 0, 1, 32'h1357_9BDF, 32'h1357_9BDF, 1'b0, 3);
    run_access(1'b0, 4'h0,    32'h0000_2000, 32'h0,         3'd3, 0, 1, 32'h80FF_7F01, 32'h0000_7F01, 1'b0, 3);
    run_access(1'b1, 4'b0010, 32'h0000_7001, 32'h0000_AB00, 3'd1, 2, 0, 32'h0,         last_rd,       1'b0, 4);

    no_access(1'b0, 4'h0, 32'h0000_3002, 3'd0, 1'b1);
    no_access(1'b0, 4'h0, 32'h0000_3001, 3'd3, 1'b1);
    no_access(1'b0, 4'h0, 32'h0000_3003, 3'd4, 1'b1);
    no_access(1'b0, 4'h0, 32'h0000_3001, 3'd6, 1'b1);
    no_access(1'b1, 4'h0, 32'h0000_3001, 3'd1, 1'b0);

    // Never granted: aborts after 8 REQ cycles with bus_err and zero data.
    run_access(1'b0, 4'h0, 32'h0000_5000, 32'h0, 3'd0, -1, 0, 32'h0, 32'h0, 1'b1, 9);
    // Grant on the final timeout cycle wins over the abort.
    run_access(1'b0, 4'h0, 32'h0000_6000, 32'h0, 3'd0, 7, 1, 32'h1234_5678, 32'h1234_5678, 1'b0, 10);

    // Reset while waiting for read data.
    @(posedge clk); #1;
    m_valid = 1'b1; m_we = 1'b0; m_byteen = '0; m_addr = 32'h0000_4000; m_ldop = 3'd0;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_rst_req", 32'(bus_if.bus_req), 32'd1);
    bus_if.bus_gnt = 1'b1;
    @(posedge clk); #1;
    bus_if.bus_gnt = 1'b0;
    check("pre_rst_stall", 32'(m_stall), 32'd1);
    #1;
    reset = 1'b1; m_valid = 1'b0;
    #1;
    check("rst_mid_req", 32'(bus_if.bus_req), 32'd0);
    check("rst_mid_stall", 32'(m_stall), 32'd0);
    check("rst_mid_w_valid", 32'(w_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    last_rd = '0;
    bus_if.bus_rvalid = 1'b1; bus_if.bus_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    bus_if.bus_rvalid = 1'b0; bus_if.bus_rdata = '0;
    @(negedge clk);
    check("post_rst_w_valid", 32'(w_valid), 32'd0);
    check("post_rst_w_rdata", w_rdata, 32'd0);
    check("post_rst_req", 32'(bus_if.bus_req), 32'd0);
    run_access(1'b0, 4'h0, 32'h0000_4000, 32'h0, 3'd0, 0, 1, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 3);

    repeat (2) @(negedge clk);
    check("sb_final_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
